// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared definitions for the servo pulse generator and any other block that
// reuses the slew limiter (e.g. the launcher path).
//   - servo_state_e : frame FSM states (IDLE / HIGH / LOW)
//   - DEF_*         : default frame constants for a 50 MHz clock, 50 Hz frame
//   - POS_W         : position code width
//   - WIDTH_W       : pulse-width arithmetic width
//   - pulse_width() : position code -> pulse width in clk cycles
// -----------------------------------------------------------------------------
package servo_pkg;

  localparam int unsigned POS_W   = 8;
  localparam int unsigned WIDTH_W = 17;

  localparam int unsigned DEF_PERIOD_CYCLES    = 1_000_000;
  localparam int unsigned DEF_MIN_PULSE_CYCLES = 50_000;
  localparam int unsigned DEF_STEP_CYCLES      = 196;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } servo_state_e;

  // Width = min + pos * step, evaluated in WIDTH_W bits (255 * 196 + 50_000
  // still fits in 17 bits).
  function automatic logic [WIDTH_W-1:0] pulse_width(
    input logic [POS_W-1:0] pos,
    input int unsigned      min_cycles,
    input int unsigned      step_cycles
  );
    return WIDTH_W'(min_cycles) + (WIDTH_W'(pos) * WIDTH_W'(step_cycles));
  endfunction

endpackage

// File: rtl/servo_slew_limiter.sv
// -----------------------------------------------------------------------------
// servo_slew_limiter
// Combinational slew limiter: moves i_cur_pos toward i_target by at most
// SLEW_STEP codes. SLEW_STEP = 0 means unlimited (jump straight to target).
// The result never wraps: a step is only taken when the distance exceeds
// SLEW_STEP, so cur +/- SLEW_STEP stays inside 0..255.
// Ports:
//   i_cur_pos [POS_W] : position currently applied
//   i_target  [POS_W] : requested position
//   o_new_pos [POS_W] : position to apply next
// -----------------------------------------------------------------------------
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic [POS_W-1:0] i_cur_pos,
  input  logic [POS_W-1:0] i_target,
  output logic [POS_W-1:0] o_new_pos
);

  localparam int unsigned DIFF_W = POS_W + 1;
  localparam logic [DIFF_W-1:0] STEP_D = DIFF_W'(SLEW_STEP);
  localparam logic [POS_W-1:0]  STEP_P = POS_W'(SLEW_STEP);
  localparam bit UNLIMITED = (SLEW_STEP == 0);

  logic [DIFF_W-1:0] w_diff;   // two's complement target - cur
  logic [DIFF_W-1:0] w_mag;    // |diff|, at most 255

  always_comb begin
    w_diff = {1'b0, i_target} - {1'b0, i_cur_pos};
    w_mag  = w_diff[DIFF_W-1] ? (~w_diff + DIFF_W'(1)) : w_diff;
    if (UNLIMITED || (w_mag <= STEP_D)) begin
      o_new_pos = i_target;
    end else if (w_diff[DIFF_W-1]) begin
      o_new_pos = i_cur_pos - STEP_P;
    end else begin
      o_new_pos = i_cur_pos + STEP_P;
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// servo_pwm_gen
// Frame-accurate servo pulse generator. Each frame is PERIOD_CYCLES long and
// begins with a pulse of width MIN_PULSE_CYCLES + cur_pos * STEP_CYCLES.
// cur_pos is slewed toward the latched target once per frame, at frame start,
// so a pulse is never truncated or stretched mid-frame.
// Ports:
//   clk         : system clock
//   reset       : asynchronous, active-low reset
//   enable      : drive enable; a frame in progress always completes
//   ready       : target qualifier; target is latched when enable & ready
//   target[8]   : requested position code
//   pulse       : PWM output (registered)
//   cur_pos[8]  : position applied to the current / most recent frame
//   at_target   : cur_pos == latched target (combinational)
//   frame_start : one-cycle strobe on the first cycle of each frame
//   dbg_state   : FSM state, exposed for checkers
// Handshake: target is taken on every rising clk edge where enable and ready
// are both 1; there is no back-pressure, ready is a pure qualifier.
// -----------------------------------------------------------------------------
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES    = DEF_PERIOD_CYCLES,
  parameter int unsigned MIN_PULSE_CYCLES = DEF_MIN_PULSE_CYCLES,
  parameter int unsigned STEP_CYCLES      = DEF_STEP_CYCLES,
  parameter int unsigned SLEW_STEP        = 4,
  parameter int unsigned INIT_POS         = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ready,
  input  logic [POS_W-1:0] target,
  output logic             pulse,
  output logic [POS_W-1:0] cur_pos,
  output logic             at_target,
  output logic             frame_start,
  output servo_state_e     dbg_state
);

  localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned CMP_W = (CNT_W > WIDTH_W) ? CNT_W : WIDTH_W;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [POS_W-1:0]   INIT_P     = POS_W'(INIT_POS);
  localparam logic [WIDTH_W-1:0] INIT_WIDTH = pulse_width(INIT_P, MIN_PULSE_CYCLES, STEP_CYCLES);

  servo_state_e       r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH_W-1:0] r_width;
  logic [POS_W-1:0]   r_cur_pos;
  logic [POS_W-1:0]   r_target;
  logic               r_pulse;
  logic               r_frame_start;

  logic [POS_W-1:0]   w_new_pos;
  logic [WIDTH_W-1:0] w_new_width;
  logic [CMP_W-1:0]   w_cnt_x;
  logic [CMP_W-1:0]   w_high_last;
  logic               w_high_done;
  logic               w_frame_last;
  logic               w_start;

  // Slew uses the target held before this edge, so a latch coinciding with
  // a frame start only affects the following frame.
  servo_slew_limiter #(
    .SLEW_STEP (SLEW_STEP)
  ) u_slew (
    .i_cur_pos (r_cur_pos),
    .i_target  (r_target),
    .o_new_pos (w_new_pos)
  );

  always_comb begin
    w_new_width  = pulse_width(w_new_pos, MIN_PULSE_CYCLES, STEP_CYCLES);
    // Counter and width are compared in a common width so neither side is
    // truncated whichever is wider.
    w_cnt_x      = CMP_W'(r_cnt);
    w_high_last  = CMP_W'(r_width) - CMP_W'(1);
    w_high_done  = (w_cnt_x == w_high_last);
    w_frame_last = (r_cnt == CNT_LAST);
    w_start      = enable &&
                   ((r_state == ST_IDLE) || ((r_state == ST_LOW) && w_frame_last));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_width       <= INIT_WIDTH;
      r_cur_pos     <= INIT_P;
      r_target      <= INIT_P;
      r_pulse       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (enable && ready) begin
        r_target <= target;
      end

      if (w_start) begin
        r_state       <= ST_HIGH;
        r_cnt         <= '0;
        r_pulse       <= 1'b1;
        r_frame_start <= 1'b1;
        r_cur_pos     <= w_new_pos;
        r_width       <= w_new_width;
      end else begin
        case (r_state)
          ST_HIGH: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_high_done) begin
              r_state <= ST_LOW;
              r_pulse <= 1'b0;
            end
          end
          ST_LOW: begin
            // Reaching here with w_frame_last means enable is low: park.
            if (w_frame_last) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_pulse <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pulse       = r_pulse;
  assign cur_pos     = r_cur_pos;
  assign frame_start = r_frame_start;
  assign at_target   = (r_cur_pos == r_target);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_gen
// Directed bench for servo_pwm_gen with shortened frame constants
// (period 1000, min 50, step 2). u_dut uses SLEW_STEP = 4, u_dut0 uses
// SLEW_STEP = 0; a select bit routes either one to the frame-measuring tasks.
// -----------------------------------------------------------------------------
module tb_servo_pwm_gen;
  import servo_pkg::*;

  localparam int PERIOD = 1000;
  localparam int MINP   = 50;
  localparam int STEP   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // u_dut signals
  logic             enable = 1'b0;
  logic             ready  = 1'b0;
  logic [7:0]       target = 8'd0;
  logic             pulse;
  logic [7:0]       cur_pos;
  logic             at_target;
  logic             frame_start;
  servo_state_e     dbg_state;

  // u_dut0 signals
  logic             enable0 = 1'b0;
  logic             ready0  = 1'b0;
  logic [7:0]       target0 = 8'd0;
  logic             pulse0;
  logic [7:0]       cur_pos0;
  logic             at_target0;
  logic             frame_start0;
  servo_state_e     dbg_state0;

  servo_pwm_gen #(
    .PERIOD_CYCLES(PERIOD), .MIN_PULSE_CYCLES(MINP), .STEP_CYCLES(STEP),
    .SLEW_STEP(4), .INIT_POS(128)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .ready(ready), .target(target),
    .pulse(pulse), .cur_pos(cur_pos), .at_target(at_target),
    .frame_start(frame_start), .dbg_state(dbg_state)
  );

  servo_pwm_gen #(
    .PERIOD_CYCLES(PERIOD), .MIN_PULSE_CYCLES(MINP), .STEP_CYCLES(STEP),
    .SLEW_STEP(0), .INIT_POS(128)
  ) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable0), .ready(ready0), .target(target0),
    .pulse(pulse0), .cur_pos(cur_pos0), .at_target(at_target0),
    .frame_start(frame_start0), .dbg_state(dbg_state0)
  );

  // measurement mux
  logic       sel = 1'b0;
  logic       m_pulse, m_fs, m_at;
  logic [7:0] m_cur;
  always_comb begin
    m_pulse = sel ? pulse0       : pulse;
    m_fs    = sel ? frame_start0 : frame_start;
    m_at    = sel ? at_target0   : at_target;
    m_cur   = sel ? cur_pos0     : cur_pos;
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next negedge on which frame_start is seen (bounded).
  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (!m_fs && n < 2500) begin
      @(negedge clk);
      n++;
    end
    check("frame_seen", 32'(m_fs), 32'd1);
  endtask

  // Call on the negedge where frame_start is 1; returns on the next one.
  task automatic frame_check(input int exp_hi, input int exp_pos, input int exp_at);
    int hi, len;
    hi  = 0;
    len = 0;
    check("cur_pos", 32'(m_cur), 32'(exp_pos));
    check("at_target", 32'(m_at), 32'(exp_at));
    do begin
      if (m_pulse) hi++;
      len++;
      @(negedge clk);
      if (len == 1) check("fs_clear", 32'(m_fs), 32'd0);
    end while (!m_fs && len < 1500);
    check("pulse_width", 32'(hi), 32'(exp_hi));
    check("frame_len", 32'(len), 32'(PERIOD));
  endtask

  initial begin
    #(1_000_000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, extra;
    servo_state_e s999, s1000;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_pulse", 32'(pulse), 32'd0);
    check("rst_cur", 32'(cur_pos), 32'd128);
    reset = 1'b1;
    @(negedge clk);
    check("idle_pulse", 32'(pulse), 32'd0);
    check("idle_fs", 32'(frame_start), 32'd0);
    check("idle_cur", 32'(cur_pos), 32'd128);
    check("idle_at", 32'(at_target), 32'd1);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // steady frames at INIT_POS
    enable = 1'b1;
    @(negedge clk);
    check("first_fs", 32'(frame_start), 32'd1);
    check("first_pulse", 32'(pulse), 32'd1);
    frame_check(306, 128, 1);

    // slew toward 140
    target = 8'd140;
    ready  = 1'b1;
    @(negedge clk);
    ready  = 1'b0;
    wait_frame();
    frame_check(314, 132, 0);
    frame_check(322, 136, 0);
    frame_check(330, 140, 1);
    frame_check(330, 140, 1);

    // latch target 0 on the frame-start edge
    repeat (999) @(negedge clk);
    target = 8'd0;
    ready  = 1'b1;
    @(negedge clk);
    ready  = 1'b0;
    check("latch_on_fs", 32'(frame_start), 32'd1);
    frame_check(330, 140, 0);
    for (int i = 1; i <= 35; i++) begin
      frame_check(MINP + STEP * (140 - 4 * i), 140 - 4 * i, (i == 35) ? 1 : 0);
    end
    frame_check(50, 0, 1);

    // drop enable 10 cycles into HIGH
    hi = 0;
    extra = 0;
    s999 = ST_IDLE;
    s1000 = ST_HIGH;
    for (int c = 0; c < 1200; c++) begin
      if (c == 10) enable = 1'b0;
      if (pulse) hi++;
      if (c > 0 && frame_start) extra++;
      if (c == 999) s999 = dbg_state;
      if (c == 1000) s1000 = dbg_state;
      @(negedge clk);
    end
    check("dis_width", 32'(hi), 32'd50);
    check("dis_no_fs", 32'(extra), 32'd0);
    check("dis_st999", 32'(s999), 32'(ST_LOW));
    check("dis_st1000", 32'(s1000), 32'(ST_IDLE));
    check("dis_pulse", 32'(pulse), 32'd0);
    check("dis_hold", 32'(cur_pos), 32'd0);

    // asynchronous reset mid-pulse
    enable = 1'b1;
    wait_frame();
    repeat (20) @(negedge clk);
    check("mid_pulse", 32'(pulse), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_pulse", 32'(pulse), 32'd0);
    check("arst_fs", 32'(frame_start), 32'd0);
    check("arst_cur", 32'(cur_pos), 32'd128);
    check("arst_at", 32'(at_target), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_frame();
    frame_check(306, 128, 1);

    // SLEW_STEP = 0 jumps in one frame
    sel     = 1'b1;
    enable0 = 1'b1;
    ready0  = 1'b1;
    target0 = 8'd255;
    @(negedge clk);
    ready0  = 1'b0;
    check("s0_fs", 32'(m_fs), 32'd1);
    frame_check(306, 128, 0);
    frame_check(560, 255, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Frame-accurate servo pulse generator that sits downstream of the instruction decoder and launcher/turntable position logic. It consumes an 8-bit target position qualified by `enable` and `ready` and produces a standard 50 Hz servo pulse. Slew limiting moves the commanded position at most `SLEW_STEP` codes per frame. Pulses are never truncated or stretched mid-frame.

## Interface
- `PERIOD_CYCLES`, 1_000_000: frame length in clk cycles (20 ms at 50 MHz).
- `MIN_PULSE_CYCLES`, 50_000: pulse width for position 0 (1 ms).
- `STEP_CYCLES`, 196: additional pulse cycles per position code (255 → 99_980 cycles).
- `SLEW_STEP`, 4: max position change per frame; 0 = unlimited (jump to target).
- `INIT_POS`, 128: position after reset.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: servo drive enable.
- `ready` in 1: instruction-valid qualifier from the decoder.
- `target` in 8: requested position code.
- `pulse` out 1: servo PWM output, registered.
- `cur_pos` out 8: position applied to the current/most recent frame.
- `at_target` out 1: `cur_pos == target_reg`.
- `frame_start` out 1: one-cycle strobe on the first cycle of each frame.

## Operation
- Reset (`reset`=0) asserts immediately: `pulse`=0, `frame_start`=0, state IDLE, counter 0, `cur_pos`=`target_reg`=`INIT_POS`, `at_target`=1. Reset mid-pulse drops `pulse` at once.
- Target latch: `target_reg` ← `target` on any edge where `enable & ready`; held otherwise.
- States:
  - IDLE: `pulse`=0. On an edge with `enable`=1, start a frame and go to HIGH.
  - HIGH: `pulse`=1. When counter == `width_reg`−1, go to LOW.
  - LOW: `pulse`=0. When counter == `PERIOD_CYCLES`−1, the frame ends. If `enable`=1, start a frame (HIGH); otherwise go to IDLE.
- Frame start, same edge:
  - counter ← 0, `frame_start` ← 1, `pulse` ← 1.
  - `cur_pos` ← slew(`cur_pos`, `target_reg`). The pre-update `target_reg` is used, so a latch on the same edge takes effect next frame.
  - `width_reg` ← `MIN_PULSE_CYCLES` + new_pos × `STEP_CYCLES`.
- Slew: diff = `target_reg` − `cur_pos`, 9-bit signed.
  - If |diff| ≤ `SLEW_STEP` or `SLEW_STEP`=0, new_pos = `target_reg`.
  - Otherwise new_pos = `cur_pos` ± `SLEW_STEP`.
  - Result is always within 0..255; no wrap.
- Disable mid-frame: the frame in progress completes unchanged, then the block goes to IDLE. `cur_pos` is held while idle.
- Re-enable from IDLE resumes slewing from the held `cur_pos`.
- Width arithmetic: 17-bit product/sum. Counter width ≥ clog2(`PERIOD_CYCLES`), i.e. 20 bits at default.

## Timing
- `enable` sampled high in IDLE at edge k: `pulse` and `frame_start` are 1 after edge k, and `frame_start` clears after edge k+1.
- `pulse` stays high for exactly `width_reg` cycles per frame.
- With `enable` continuously high, frames are exactly `PERIOD_CYCLES` cycles long; `frame_start` recurs every `PERIOD_CYCLES` cycles.
- Latency from a target latch to the pulse change is at most one frame plus one cycle.
- `at_target` is combinational from registers and has no added latency.
- All outputs are glitch-free registered values except `at_target`.

## Structure
- Shared package `servo_pkg` contains:
  - the state enum (IDLE/HIGH/LOW);
  - default frame constants (period, min pulse, step);
  - the position width (8).
- Sub-module `servo_slew_limiter`: combinational `cur_pos`, `target`, `SLEW_STEP` → `new_pos`. It is reused by the launcher path.
- The top level holds the FSM, counter, width register and target latch.

## Test plan
Sim parameters: `PERIOD_CYCLES`=1000, `MIN_PULSE_CYCLES`=50, `STEP_CYCLES`=2, `SLEW_STEP`=4, `INIT_POS`=128.
- Reset, then hold `enable`=1 with no `ready` → pulse high 306 cycles per 1000-cycle frame, `cur_pos`=128, `at_target`=1.
- `target`=140 with `ready` pulse, `enable`=1 → widths 314, 322, 330, then 330 steady; `cur_pos` 132, 136, 140; `at_target` rises in the frame reaching 140.
- `target`=0 latched on the same edge as `frame_start` → that frame still uses the old target; the next frame is 4 codes lower; `cur_pos` saturates at 0 (width 50), never wraps.
- `enable` dropped 10 cycles into HIGH → pulse completes full width, frame runs to 1000 cycles, then IDLE with `pulse`=0 and no `frame_start`.
- `reset` asserted mid-pulse → `pulse`=0 asynchronously; after release with `enable`=1 the first frame is 306 cycles wide.
- `SLEW_STEP`=0, `target`=255 → next frame is 560 cycles wide, `cur_pos`=255.
